// File: rtl/trig_capture.sv
// Trigger combine and circular sample-capture sequencer for the sample RAM.
// Optional TRIG_TIMESTAMP_EN adds trig_ts: smpl_en strobes counted from armed to trigger.
module trig_capture #(
  parameter int ENTRIES = 384,
  parameter int AW      = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    ch_trig,
  input  logic          prot_trig,
  input  logic          run,
  input  logic          smpl_en,
  input  logic [AW-1:0] trig_pos,
  input  logic          clr_done,
  output logic          armed,
  output logic          triggered,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [AW-1:0] trig_addr,
  output logic          capture_done
`ifdef TRIG_TIMESTAMP_EN
  ,
  output logic [15:0]   trig_ts
`endif
);

  localparam logic [AW-1:0] LAST = AW'(ENTRIES - 1);
  localparam logic [AW:0]   FULL = (AW+1)'(ENTRIES);

  typedef enum logic [1:0] {IDLE, FILL, TRIG, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] waddr_q, trig_cnt, tp;
  logic [AW:0]   smpl_cnt, arm_thr;
  logic          armed_q, trig_set, trig_last, wr_fill, wr_trig;

  always_comb begin
    tp      = (trig_pos > LAST) ? LAST : trig_pos;
    arm_thr = FULL - {1'b0, tp};
  end

  always_comb begin
    state_nxt = state;
    trig_set  = 1'b0;
    trig_last = 1'b0;
    wr_fill   = 1'b0;
    wr_trig   = 1'b0;
    case (state)
      IDLE: if (run) state_nxt = FILL;
      FILL: begin
        wr_fill  = smpl_en;
        trig_set = armed_q & (&ch_trig) & prot_trig;
        if (!run)          state_nxt = IDLE;
        else if (trig_set) state_nxt = TRIG;
      end
      TRIG: begin
        // trig_pos=0 finishes without writing any post-trigger sample
        wr_trig   = smpl_en & (tp != '0);
        trig_last = (tp == '0) | (wr_trig & ((trig_cnt + AW'(1)) == tp));
        if (!run)           state_nxt = IDLE;
        else if (trig_last) state_nxt = DONE;
      end
      DONE: if (clr_done || !run) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      waddr_q  <= '0;
      smpl_cnt <= '0;
      trig_cnt <= '0;
      armed_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == IDLE) begin
        waddr_q  <= '0;
        smpl_cnt <= '0;
        trig_cnt <= '0;
        armed_q  <= 1'b0;
      end else begin
        if (we) waddr_q <= (waddr_q == LAST) ? '0 : waddr_q + AW'(1);
        if (wr_fill && smpl_cnt != FULL) smpl_cnt <= smpl_cnt + (AW+1)'(1);
        // Registered so a trigger can never be accepted in the arming cycle
        if (state == FILL && smpl_cnt >= arm_thr) armed_q <= 1'b1;
        if (trig_set)     trig_cnt <= '0;
        else if (wr_trig) trig_cnt <= trig_cnt + AW'(1);
      end
    end
  end

  always_comb begin
    we           = wr_fill | wr_trig;
    waddr        = waddr_q;
    armed        = armed_q & ((state == FILL) | (state == TRIG));
    triggered    = (state == TRIG) | (state == DONE);
    capture_done = (state == DONE);
    trig_addr    = '0;
    if (state == DONE) trig_addr = (waddr_q == '0) ? LAST : waddr_q - AW'(1);
  end

`ifdef TRIG_TIMESTAMP_EN
  logic [15:0] ts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q <= '0;
    end else if (state_nxt == IDLE) begin
      ts_q <= '0;
    end else if (state == FILL && armed_q && smpl_en && ts_q != 16'hFFFF) begin
      ts_q <= ts_q + 16'd1;
    end
  end

  assign trig_ts = ts_q;
`endif

endmodule
